// File: rtl/shifter_if.sv
// Operand/result bundle for the registered barrel shifter.
// The master drives operands; the slave returns the result.
interface shifter_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic [WIDTH-1:0] in;
    logic [SHW-1:0]   shamt;
    logic [1:0]       op;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             zero;

    modport master (
        output in, shamt, op, in_valid,
        input  out, out_valid, zero
    );

    modport slave (
        input  in, shamt, op, in_valid,
        output out, out_valid, zero
    );
endinterface

// File: rtl/shifter.sv
// Single-cycle registered log shifter: SLL, SRL, SRA, ROL.
// Four mux stages, stage k shifting by 2^k when shamt[k] is set.
module shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input logic      clk,
    input logic      reset,
    shifter_if.slave bus
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    function automatic logic [WIDTH-1:0] stage_f(
        input logic [WIDTH-1:0] x,
        input logic [1:0]       op,
        input int unsigned      s
    );
        logic [WIDTH-1:0] r;
        r = x;
        unique case (op)
            OP_SLL: r = x << s;
            OP_SRL: r = x >> s;
            OP_SRA: r = WIDTH'($signed(x) >>> s);
            OP_ROL: r = (x << s) | (x >> (WIDTH - s));
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] out_d, out_q;
    logic             zero_d, zero_q;
    logic             valid_q;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] res;
        if (k == 0) begin : g_first
            assign src = bus.in;
        end else begin : g_next
            assign src = g_stage[k-1].res;
        end
        assign res = bus.shamt[k]
                   ? stage_f(src, bus.op, 2 ** k)
                   : src;
    end

    assign out_d  = g_stage[SHW-1].res;
    assign zero_d = (out_d == '0);

    // Result and flag hold across idle cycles; only valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_q  <= out_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_shifter.sv
// Self-checking bench for shifter: directed table, corner
// sequences and randomized traffic against a bit-level model.
module tb_shifter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shifter_if #(.WIDTH(16), .SHW(4)) bus ();
    shifter #(.WIDTH(16), .SHW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] m_out;
    logic        m_val;
    logic        m_zero;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  sh;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] ref_f(
        input logic [15:0] x,
        input int          s,
        input logic [1:0]  op
    );
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case (op)
                2'b00: if (i >= s) r[i] = x[i-s];
                2'b01: if (i + s < 16) r[i] = x[i+s];
                2'b10: r[i] = (i + s < 16) ? x[i+s] : x[15];
                default: r[i] = x[(i - s + 16) % 16];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string nm,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic v,
                         input logic [15:0] din,
                         input logic [3:0] sh,
                         input logic [1:0] op);
        logic [15:0] r;
        reset        = rst;
        bus.in_valid = v;
        bus.in       = din;
        bus.shamt    = sh;
        bus.op       = op;
        @(posedge clk);
        if (rst) begin
            m_out = '0; m_val = 1'b0; m_zero = 1'b0;
        end else if (v) begin
            r = ref_f(din, int'(sh), op);
            m_out = r; m_val = 1'b1; m_zero = (r == 16'h0);
        end else begin
            m_val = 1'b0;
        end
        @(negedge clk);
        check("out", bus.out, m_out);
        check("out_valid", 16'(bus.out_valid), 16'(m_val));
        check("zero", 16'(bus.zero), 16'(m_zero));
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in = '0;
        bus.shamt = '0;
        bus.op = '0;
        m_out = '0; m_val = 1'b0; m_zero = 1'b0;
        @(negedge clk);

        // Reset state, with in_valid high
        cycle(1'b1, 1'b1, 16'hFFFF, 4'd1, 2'b00);
        check("rst_out", bus.out, 16'h0000);

        tbl.push_back('{16'h000F, 4'd3,  2'b00, 16'h0078});
        tbl.push_back('{16'h8000, 4'd3,  2'b10, 16'hF000});
        tbl.push_back('{16'h8000, 4'd3,  2'b01, 16'h1000});
        tbl.push_back('{16'h8001, 4'd1,  2'b11, 16'h0003});
        tbl.push_back('{16'h1234, 4'd0,  2'b00, 16'h1234});
        tbl.push_back('{16'h1234, 4'd0,  2'b01, 16'h1234});
        tbl.push_back('{16'h1234, 4'd0,  2'b10, 16'h1234});
        tbl.push_back('{16'h1234, 4'd0,  2'b11, 16'h1234});
        tbl.push_back('{16'h0001, 4'd15, 2'b01, 16'h0000});
        tbl.push_back('{16'h8001, 4'd15, 2'b00, 16'h8000});
        tbl.push_back('{16'h8001, 4'd15, 2'b01, 16'h0001});
        tbl.push_back('{16'h8001, 4'd15, 2'b10, 16'hFFFF});
        tbl.push_back('{16'h7FFF, 4'd15, 2'b10, 16'h0000});
        tbl.push_back('{16'h1234, 4'd4,  2'b11, 16'h2341});
        tbl.push_back('{16'h1234, 4'd15, 2'b11, 16'h091A});

        foreach (tbl[i]) begin
            cycle(1'b0, 1'b1, tbl[i].din, tbl[i].sh, tbl[i].op);
            check("tbl_out", bus.out, tbl[i].exp);
            check("tbl_zero", 16'(bus.zero),
                  16'(tbl[i].exp == 16'h0));
        end

        // Back-to-back results keep order
        cycle(1'b0, 1'b1, 16'h0001, 4'd1, 2'b00);
        check("b2b_0", bus.out, 16'h0002);
        cycle(1'b0, 1'b1, 16'h0001, 4'd2, 2'b00);
        check("b2b_1", bus.out, 16'h0004);
        cycle(1'b0, 1'b1, 16'h0001, 4'd3, 2'b00);
        check("b2b_2", bus.out, 16'h0008);

        // Hold, then reset clears the held result
        cycle(1'b0, 1'b1, 16'h000F, 4'd3, 2'b00);
        cycle(1'b0, 1'b0, 16'hAAAA, 4'd5, 2'b01);
        check("hold_out", bus.out, 16'h0078);
        check("hold_vld", 16'(bus.out_valid), 16'h0);
        cycle(1'b1, 1'b1, 16'h00FF, 4'd0, 2'b00);
        check("rst_clr", bus.out, 16'h0000);
        check("rst_vld", 16'(bus.out_valid), 16'h0);
        cycle(1'b0, 1'b1, 16'h8000, 4'd3, 2'b10);
        check("post_rst", bus.out, 16'hF000);

        // Zero flag holds through idle
        cycle(1'b0, 1'b1, 16'h0001, 4'd15, 2'b01);
        cycle(1'b0, 1'b0, 16'h0000, 4'd0, 2'b00);
        check("zero_hold", 16'(bus.zero), 16'h1);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  16'($urandom),
                  4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
